// File: rtl/core_mem_bridge_if.sv
// Bundles the core memory-access port and the downstream in-order memory port of
// core_mem_bridge. The bridge uses the master view; the core/memory environment uses the slave view.
interface core_mem_bridge_if #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 128,
  parameter int RSERIAL_WIDTH = 4,
  parameter int WSERIAL_WIDTH = 4
) ();
  // Core side
  logic [ADDR_WIDTH-1:0]    memAccessAddr;
  logic [DATA_WIDTH-1:0]    memAccessWriteData;
  logic                     memAccessRE;
  logic                     memAccessWE;
  logic                     memAccessReadBusy;
  logic                     memAccessWriteBusy;
  logic [RSERIAL_WIDTH-1:0] nextMemReadSerial;
  logic [WSERIAL_WIDTH-1:0] nextMemWriteSerial;
  logic                     memReadDataReady;
  logic [DATA_WIDTH-1:0]    memReadData;
  logic [RSERIAL_WIDTH-1:0] memReadSerial;
  logic                     memAccessResponseValid;
  logic [WSERIAL_WIDTH-1:0] memAccessResponseSerial;
  // Memory side
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic                     mem_req_we;
  logic [ADDR_WIDTH-1:0]    mem_req_addr;
  logic [DATA_WIDTH-1:0]    mem_req_wdata;
  logic                     mem_rsp_valid;
  logic [DATA_WIDTH-1:0]    mem_rsp_rdata;

  modport master (
    input  memAccessAddr, memAccessWriteData, memAccessRE, memAccessWE,
    output memAccessReadBusy, memAccessWriteBusy, nextMemReadSerial, nextMemWriteSerial,
    output memReadDataReady, memReadData, memReadSerial,
    output memAccessResponseValid, memAccessResponseSerial,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    output memAccessAddr, memAccessWriteData, memAccessRE, memAccessWE,
    input  memAccessReadBusy, memAccessWriteBusy, nextMemReadSerial, nextMemWriteSerial,
    input  memReadDataReady, memReadData, memReadSerial,
    input  memAccessResponseValid, memAccessResponseSerial,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/core_mem_bridge.sv
// Core-to-memory bridge: serial assignment, request FIFO, in-order response tracker, busy back-pressure.
// Define CORE_MEM_BRIDGE_PERF_COUNTER_EN to add saturating read/write/busy-cycle counters.
module core_mem_bridge #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 128,
  parameter int RSERIAL_WIDTH   = 4,
  parameter int WSERIAL_WIDTH   = 4,
  parameter int REQ_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              clk,
  input  logic              rst,
  core_mem_bridge_if.master bus,
  output logic              proto_error
`ifdef CORE_MEM_BRIDGE_PERF_COUNTER_EN
  ,
  output logic [31:0]       perf_read_count,
  output logic [31:0]       perf_write_count,
  output logic [31:0]       perf_busy_cycles
`endif
);
  localparam int SW  = (RSERIAL_WIDTH > WSERIAL_WIDTH) ? RSERIAL_WIDTH : WSERIAL_WIDTH;
  localparam int RPW = $clog2(REQ_DEPTH);
  localparam int RCW = $clog2(REQ_DEPTH + 1);
  localparam int TPW = $clog2(MAX_OUTSTANDING);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [RCW-1:0] REQ_FULL = RCW'(REQ_DEPTH);
  localparam logic [OW-1:0]  OCC_FULL = OW'(MAX_OUTSTANDING);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]         serial;
  } req_t;

  typedef struct packed {
    logic          we;
    logic [SW-1:0] serial;
  } trk_t;

  req_t [REQ_DEPTH-1:0]       req_mem_q, req_mem_d;
  logic [RPW-1:0]             req_wp_q, req_wp_d, req_rp_q, req_rp_d;
  logic [RCW-1:0]             req_cnt_q, req_cnt_d;
  trk_t [MAX_OUTSTANDING-1:0] trk_mem_q, trk_mem_d;
  logic [TPW-1:0]             trk_wp_q, trk_wp_d, trk_rp_q, trk_rp_d;
  logic [OW-1:0]              trk_cnt_q, trk_cnt_d;
  logic [OW-1:0]              occ_q, occ_d;
  logic [RSERIAL_WIDTH-1:0]   rserial_q, rserial_d;
  logic [WSERIAL_WIDTH-1:0]   wserial_q, wserial_d;
  logic                       rd_vld_q, rd_vld_d, wr_vld_q, wr_vld_d;
  logic [DATA_WIDTH-1:0]      rd_data_q, rd_data_d;
  logic [RSERIAL_WIDTH-1:0]   rd_ser_q, rd_ser_d;
  logic [WSERIAL_WIDTH-1:0]   wr_ser_q, wr_ser_d;
  logic                       proto_q, proto_d;

  logic busy, acc_rd, acc_wr, push, pop, rsp;
  req_t head;
  trk_t thead;

  // Downstream handshake: a request transfers on any rising edge where mem_req_valid && mem_req_ready;
  // valid never waits on ready and the head fields stay stable until that edge. Responses need no ready.
  assign busy   = (req_cnt_q == REQ_FULL) || (occ_q == OCC_FULL);
  assign acc_rd = bus.memAccessRE && !busy;
  assign acc_wr = bus.memAccessWE && !bus.memAccessRE && !busy;
  assign push   = acc_rd || acc_wr;
  assign pop    = (req_cnt_q != '0) && bus.mem_req_ready;
  assign rsp    = bus.mem_rsp_valid && (trk_cnt_q != '0);
  assign head   = req_mem_q[req_rp_q];
  assign thead  = trk_mem_q[trk_rp_q];

  always_comb begin
    req_mem_d = req_mem_q;
    req_wp_d  = req_wp_q;
    req_rp_d  = req_rp_q;
    trk_mem_d = trk_mem_q;
    trk_wp_d  = trk_wp_q;
    trk_rp_d  = trk_rp_q;
    rserial_d = rserial_q;
    wserial_d = wserial_q;
    rd_vld_d  = 1'b0;
    wr_vld_d  = 1'b0;
    rd_data_d = rd_data_q;
    rd_ser_d  = rd_ser_q;
    wr_ser_d  = wr_ser_q;
    if (push) begin
      req_mem_d[req_wp_q].we     = acc_wr;
      req_mem_d[req_wp_q].addr   = bus.memAccessAddr;
      req_mem_d[req_wp_q].wdata  = bus.memAccessWriteData;
      req_mem_d[req_wp_q].serial = acc_wr ? SW'(wserial_q) : SW'(rserial_q);
      req_wp_d = req_wp_q + RPW'(1);
    end
    if (acc_rd) rserial_d = rserial_q + RSERIAL_WIDTH'(1);
    if (acc_wr) wserial_d = wserial_q + WSERIAL_WIDTH'(1);
    if (pop) begin
      req_rp_d = req_rp_q + RPW'(1);
      trk_mem_d[trk_wp_q].we     = head.we;
      trk_mem_d[trk_wp_q].serial = head.serial;
      trk_wp_d = trk_wp_q + TPW'(1);
    end
    if (rsp) begin
      trk_rp_d = trk_rp_q + TPW'(1);
      if (thead.we) begin
        wr_vld_d = 1'b1;
        wr_ser_d = thead.serial[WSERIAL_WIDTH-1:0];
      end else begin
        rd_vld_d  = 1'b1;
        rd_data_d = bus.mem_rsp_rdata;
        rd_ser_d  = thead.serial[RSERIAL_WIDTH-1:0];
      end
    end
    // Occupancy counts queued plus in-flight, so it is bounded by the tracker size.
    req_cnt_d = req_cnt_q + RCW'(push) - RCW'(pop);
    trk_cnt_d = trk_cnt_q + OW'(pop) - OW'(rsp);
    occ_d     = occ_q + OW'(push) - OW'(rsp);
    proto_d   = proto_q || (bus.memAccessRE && bus.memAccessWE) ||
                (bus.mem_rsp_valid && (trk_cnt_q == '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_mem_q <= '0;
      trk_mem_q <= '0;
      req_wp_q  <= '0;
      req_rp_q  <= '0;
      req_cnt_q <= '0;
      trk_wp_q  <= '0;
      trk_rp_q  <= '0;
      trk_cnt_q <= '0;
      occ_q     <= '0;
      rserial_q <= '0;
      wserial_q <= '0;
      rd_vld_q  <= 1'b0;
      wr_vld_q  <= 1'b0;
      rd_data_q <= '0;
      rd_ser_q  <= '0;
      wr_ser_q  <= '0;
      proto_q   <= 1'b0;
    end else begin
      req_mem_q <= req_mem_d;
      trk_mem_q <= trk_mem_d;
      req_wp_q  <= req_wp_d;
      req_rp_q  <= req_rp_d;
      req_cnt_q <= req_cnt_d;
      trk_wp_q  <= trk_wp_d;
      trk_rp_q  <= trk_rp_d;
      trk_cnt_q <= trk_cnt_d;
      occ_q     <= occ_d;
      rserial_q <= rserial_d;
      wserial_q <= wserial_d;
      rd_vld_q  <= rd_vld_d;
      wr_vld_q  <= wr_vld_d;
      rd_data_q <= rd_data_d;
      rd_ser_q  <= rd_ser_d;
      wr_ser_q  <= wr_ser_d;
      proto_q   <= proto_d;
    end
  end

  assign bus.memAccessReadBusy       = busy;
  assign bus.memAccessWriteBusy      = busy;
  assign bus.nextMemReadSerial       = rserial_q;
  assign bus.nextMemWriteSerial      = wserial_q;
  assign bus.memReadDataReady        = rd_vld_q;
  assign bus.memReadData             = rd_data_q;
  assign bus.memReadSerial           = rd_ser_q;
  assign bus.memAccessResponseValid  = wr_vld_q;
  assign bus.memAccessResponseSerial = wr_ser_q;
  assign bus.mem_req_valid           = (req_cnt_q != '0);
  assign bus.mem_req_we              = head.we;
  assign bus.mem_req_addr            = head.addr;
  assign bus.mem_req_wdata           = head.wdata;
  assign proto_error                 = proto_q;

`ifdef CORE_MEM_BRIDGE_PERF_COUNTER_EN
  logic [31:0] perf_rd_q, perf_rd_d, perf_wr_q, perf_wr_d, perf_busy_q, perf_busy_d;

  always_comb begin
    perf_rd_d   = perf_rd_q;
    perf_wr_d   = perf_wr_q;
    perf_busy_d = perf_busy_q;
    if (acc_rd && (perf_rd_q != 32'hFFFF_FFFF)) perf_rd_d = perf_rd_q + 32'd1;
    if (acc_wr && (perf_wr_q != 32'hFFFF_FFFF)) perf_wr_d = perf_wr_q + 32'd1;
    if ((bus.memAccessRE || bus.memAccessWE) && busy && (perf_busy_q != 32'hFFFF_FFFF))
      perf_busy_d = perf_busy_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_rd_q   <= '0;
      perf_wr_q   <= '0;
      perf_busy_q <= '0;
    end else begin
      perf_rd_q   <= perf_rd_d;
      perf_wr_q   <= perf_wr_d;
      perf_busy_q <= perf_busy_d;
    end
  end

  assign perf_read_count  = perf_rd_q;
  assign perf_write_count = perf_wr_q;
  assign perf_busy_cycles = perf_busy_q;
`endif
endmodule

// File: tb/tb_core_mem_bridge.sv
// Directed bench for core_mem_bridge: hand-computed vectors, response scoreboard on an expected queue.
module tb_core_mem_bridge;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic proto_error;
`ifdef CORE_MEM_BRIDGE_PERF_COUNTER_EN
  logic [31:0] perf_read_count, perf_write_count, perf_busy_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [DW+SW:0] exp_q[$];  // {is_write, serial, read data}

  logic          auto_en   = 1'b0;
  logic          auto_vld  = 1'b0;
  logic [DW-1:0] auto_data = '0;
  logic          man_vld   = 1'b0;
  logic [DW-1:0] man_data  = '0;

  core_mem_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSERIAL_WIDTH(SW), .WSERIAL_WIDTH(SW)) bus ();

  core_mem_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSERIAL_WIDTH(SW), .WSERIAL_WIDTH(SW),
    .REQ_DEPTH(4), .MAX_OUTSTANDING(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .proto_error(proto_error)
`ifdef CORE_MEM_BRIDGE_PERF_COUNTER_EN
    ,
    .perf_read_count(perf_read_count),
    .perf_write_count(perf_write_count),
    .perf_busy_cycles(perf_busy_cycles)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Memory model: auto mode answers every handshake in the following cycle with {4{addr}}.
  always @(posedge clk) begin
    auto_vld  <= bus.mem_req_valid && bus.mem_req_ready;
    auto_data <= {4{bus.mem_req_addr}};
  end
  assign bus.mem_rsp_valid = auto_en ? auto_vld : man_vld;
  assign bus.mem_rsp_rdata = auto_en ? auto_data : man_data;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_push(input logic we, input logic [SW-1:0] ser, input logic [DW-1:0] d);
    exp_q.push_back({we, ser, d});
  endtask

  task automatic do_reset();
    check("exp_q_drained", exp_q.size(), 0);
    rst = 1'b0;
    bus.memAccessRE = 1'b0;
    bus.memAccessWE = 1'b0;
    bus.memAccessAddr = '0;
    bus.memAccessWriteData = '0;
    bus.mem_req_ready = 1'b0;
    auto_en = 1'b0;
    man_vld = 1'b0;
    man_data = '0;
    tick(2);
    rst = 1'b1;
  endtask

  // Scoreboard: every response pulse is matched against the head of exp_q
  always @(negedge clk) begin
    logic [DW+SW:0] e;
    if (rst && (bus.memReadDataReady || bus.memAccessResponseValid)) begin
      check("pulse_overlap", DW'(bus.memReadDataReady & bus.memAccessResponseValid), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", DW'({bus.memReadDataReady, bus.memAccessResponseValid}), 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_is_write", DW'(bus.memAccessResponseValid), DW'(e[DW+SW]));
        if (e[DW+SW]) begin
          check("wr_serial", DW'(bus.memAccessResponseSerial), DW'(e[DW+SW-1:DW]));
        end else begin
          check("rd_serial", DW'(bus.memReadSerial), DW'(e[DW+SW-1:DW]));
          check("rd_data", bus.memReadData, e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    bus.memAccessRE = 1'b0;
    bus.memAccessWE = 1'b0;
    bus.memAccessAddr = '0;
    bus.memAccessWriteData = '0;
    bus.mem_req_ready = 1'b0;
    tick(2);
    check("rst_req_valid", DW'(bus.mem_req_valid), 0);
    check("rst_rd_pulse", DW'(bus.memReadDataReady), 0);
    check("rst_next_rs", DW'(bus.nextMemReadSerial), 0);
    check("rst_busy", DW'(bus.memAccessReadBusy), 0);
    check("rst_proto", DW'(proto_error), 0);

    // Single read, response three cycles after the handshake
    do_reset();
    bus.mem_req_ready = 1'b1;
    bus.memAccessAddr = 32'h1000;
    bus.memAccessRE = 1'b1;
    exp_push(1'b0, 4'd0, {16{8'hA5}});
    tick();
    bus.memAccessRE = 1'b0;
    check("t1_req_valid", DW'(bus.mem_req_valid), 1);
    check("t1_req_addr", DW'(bus.mem_req_addr), 128'h1000);
    check("t1_req_we", DW'(bus.mem_req_we), 0);
    check("t1_next_rs", DW'(bus.nextMemReadSerial), 1);
    tick();
    check("t1_req_popped", DW'(bus.mem_req_valid), 0);
    tick(2);
    man_vld = 1'b1;
    man_data = {16{8'hA5}};
    check("t1_no_early_pulse", DW'(bus.memReadDataReady), 0);
    tick();
    man_vld = 1'b0;
    check("t1_rd_pulse", DW'(bus.memReadDataReady), 1);
    tick();
    check("t1_pulse_ends", DW'(bus.memReadDataReady), 0);
    check("t1_data_held", bus.memReadData, {16{8'hA5}});

    // Write / read / write with immediate responses
    do_reset();
    bus.mem_req_ready = 1'b1;
    auto_en = 1'b1;
    bus.memAccessWE = 1'b1;
    bus.memAccessAddr = 32'h40;
    bus.memAccessWriteData = 128'h1111;
    exp_push(1'b1, 4'd0, '0);
    tick();
    check("t2_req_we", DW'(bus.mem_req_we), 1);
    check("t2_req_wdata", bus.mem_req_wdata, 128'h1111);
    bus.memAccessWE = 1'b0;
    bus.memAccessRE = 1'b1;
    bus.memAccessAddr = 32'h50;
    exp_push(1'b0, 4'd0, {4{32'h50}});
    tick();
    bus.memAccessRE = 1'b0;
    bus.memAccessWE = 1'b1;
    bus.memAccessAddr = 32'h60;
    exp_push(1'b1, 4'd1, '0);
    tick();
    bus.memAccessWE = 1'b0;
    tick(6);
    check("t2_next_ws", DW'(bus.nextMemWriteSerial), 2);
    check("t2_next_rs", DW'(bus.nextMemReadSerial), 1);

    // FIFO fills while downstream stalls
    do_reset();
    for (int i = 0; i < 5; i++) begin
      check("t3_busy", DW'(bus.memAccessReadBusy), DW'(i == 4));
      bus.memAccessRE = 1'b1;
      bus.memAccessAddr = 32'h100 + 32'(16 * i);
      if (i < 4) exp_push(1'b0, SW'(i), {4{bus.memAccessAddr}});
      tick();
    end
    bus.memAccessRE = 1'b0;
    check("t3_next_rs", DW'(bus.nextMemReadSerial), 4);
    check("t3_wbusy", DW'(bus.memAccessWriteBusy), 1);
    check("t3_head_held", DW'(bus.mem_req_addr), 128'h100);
    bus.mem_req_ready = 1'b1;
    auto_en = 1'b1;
    tick();
    check("t3_busy_released", DW'(bus.memAccessReadBusy), 0);
    tick(8);

    // Outstanding limit, then serial wrap
    do_reset();
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check("t4_occ_busy", DW'(bus.memAccessReadBusy), DW'(i == 8));
      bus.memAccessRE = 1'b1;
      bus.memAccessAddr = 32'h2000 + 32'(4 * i);
      tick();
    end
    bus.memAccessRE = 1'b0;
    check("t4_next_rs", DW'(bus.nextMemReadSerial), 8);
    for (int k = 0; k < 8; k++) begin
      man_vld = 1'b1;
      man_data = {4{32'hD000_0000 + 32'(k)}};
      exp_push(1'b0, SW'(k), man_data);
      tick();
    end
    man_vld = 1'b0;
    tick();
    check("t4_busy_cleared", DW'(bus.memAccessReadBusy), 0);
    auto_en = 1'b1;
    for (int i = 8; i < 17; i++) begin
      if (i == 16) check("t4_serial_wrap", DW'(bus.nextMemReadSerial), 0);
      bus.memAccessRE = 1'b1;
      bus.memAccessAddr = 32'h2000 + 32'(4 * i);
      exp_push(1'b0, SW'(i), {4{bus.memAccessAddr}});
      tick();
    end
    bus.memAccessRE = 1'b0;
    check("t4_next_rs_after_wrap", DW'(bus.nextMemReadSerial), 1);
    tick(6);

    // RE and WE together, then reset mid-transfer
    do_reset();
    bus.mem_req_ready = 1'b1;
    auto_en = 1'b1;
    bus.memAccessRE = 1'b1;
    bus.memAccessWE = 1'b1;
    bus.memAccessAddr = 32'h20;
    bus.memAccessWriteData = '1;
    exp_push(1'b0, 4'd0, {4{32'h20}});
    tick();
    bus.memAccessRE = 1'b0;
    bus.memAccessWE = 1'b0;
    check("t5_proto_set", DW'(proto_error), 1);
    check("t5_req_is_read", DW'(bus.mem_req_we), 0);
    check("t5_next_ws", DW'(bus.nextMemWriteSerial), 0);
    check("t5_next_rs", DW'(bus.nextMemReadSerial), 1);
    tick(5);
    check("t5_proto_sticky", DW'(proto_error), 1);
    bus.mem_req_ready = 1'b0;
    auto_en = 1'b0;
    bus.memAccessWE = 1'b1;
    bus.memAccessAddr = 32'h30;
    tick();
    bus.memAccessWE = 1'b0;
    check("t5_write_pending", DW'(bus.mem_req_valid), 1);
    rst = 1'b0;
    #1;
    check("t5_rst_req_valid", DW'(bus.mem_req_valid), 0);
    check("t5_rst_proto", DW'(proto_error), 0);
    check("t5_rst_next_ws", DW'(bus.nextMemWriteSerial), 0);
    check("t5_rst_next_rs", DW'(bus.nextMemReadSerial), 0);
    check("t5_rst_req_addr", DW'(bus.mem_req_addr), 0);
    check("t5_rst_rd_data", bus.memReadData, 0);
    tick();
    rst = 1'b1;
    bus.mem_req_ready = 1'b1;
    auto_en = 1'b1;
    bus.memAccessWE = 1'b1;
    bus.memAccessAddr = 32'h34;
    exp_push(1'b1, 4'd0, '0);
    tick();
    bus.memAccessWE = 1'b0;
    tick(4);
    check("t5_restart_ws", DW'(bus.nextMemWriteSerial), 1);

    // Response with nothing outstanding
    do_reset();
    man_vld = 1'b1;
    tick();
    man_vld = 1'b0;
    check("t6_stray_rsp_proto", DW'(proto_error), 1);
    tick();

`ifdef CORE_MEM_BRIDGE_PERF_COUNTER_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.memAccessRE = 1'b1;
      bus.memAccessAddr = 32'h300 + 32'(16 * i);
      exp_push(1'b0, SW'(i), {4{bus.memAccessAddr}});
      tick();
    end
    bus.memAccessRE = 1'b0;
    bus.memAccessWE = 1'b1;
    bus.memAccessAddr = 32'h330;
    exp_push(1'b1, 4'd0, '0);
    tick();
    bus.memAccessWE = 1'b0;
    bus.memAccessRE = 1'b1;
    bus.memAccessAddr = 32'h400;
    tick(5);
    bus.memAccessRE = 1'b0;
    check("p_busy_cycles", DW'(perf_busy_cycles), 5);
    check("p_reads", DW'(perf_read_count), 3);
    check("p_writes_mid", DW'(perf_write_count), 1);
    bus.mem_req_ready = 1'b1;
    auto_en = 1'b1;
    tick(6);
    bus.memAccessWE = 1'b1;
    bus.memAccessAddr = 32'h340;
    exp_push(1'b1, 4'd1, '0);
    tick();
    bus.memAccessWE = 1'b0;
    tick(4);
    check("p_writes", DW'(perf_write_count), 2);
    check("p_reads_final", DW'(perf_read_count), 3);
    check("p_busy_final", DW'(perf_busy_cycles), 5);
`endif

    check("exp_q_drained_final", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/core_mem_bridge.md
Name: core_mem_bridge

Overview:
- Sits directly downstream of the core's memory access port; consumes its read/write requests and produces its read-data, serial and write-completion inputs.
- Assigns read/write serials and buffers requests in a FIFO toward a simple in-order valid/ready memory port.
- Tracks outstanding transactions and returns read data and write acknowledgements to the core, tagged with the original serial.
- Generates the core's read/write busy back-pressure.

Parameters:
ADDR_WIDTH, 32, physical address width
DATA_WIDTH, 128, memory entry (cache line) width
RSERIAL_WIDTH, 4, read serial width
WSERIAL_WIDTH, 4, write serial width
REQ_DEPTH, 4, request FIFO entries (power of 2)
MAX_OUTSTANDING, 8, tracker entries (power of 2, ≤ 2^RSERIAL_WIDTH and ≤ 2^WSERIAL_WIDTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (asserted at 0)
memAccessAddr  in  ADDR_WIDTH  request address
memAccessWriteData  in  DATA_WIDTH  write data
memAccessRE  in  1  read request
memAccessWE  in  1  write request
memAccessReadBusy  out  1  read not acceptable this cycle
memAccessWriteBusy  out  1  write not acceptable this cycle
nextMemReadSerial  out  RSERIAL_WIDTH  serial for next accepted read
nextMemWriteSerial  out  WSERIAL_WIDTH  serial for next accepted write
memReadDataReady  out  1  read data valid (one-cycle pulse)
memReadData  out  DATA_WIDTH  returned line
memReadSerial  out  RSERIAL_WIDTH  serial of returned read
memAccessResponseValid  out  1  write completion pulse
memAccessResponseSerial  out  WSERIAL_WIDTH  serial of completed write
mem_req_valid  out  1  downstream request valid
mem_req_ready  in  1  downstream accepts
mem_req_we  out  1  1 = write
mem_req_addr  out  ADDR_WIDTH  downstream address
mem_req_wdata  out  DATA_WIDTH  downstream write data
mem_rsp_valid  in  1  downstream response, strictly in request order
mem_rsp_rdata  in  DATA_WIDTH  read data (ignored for writes)
proto_error  out  1  sticky: RE and WE asserted together

Behaviour:
- Reset (rst=0, async): FIFO and tracker empty; serial counters 0; all outputs 0. Busy flags are then recomputed from empty state (0).
- Busy:
  - memAccessReadBusy = FIFO full OR tracker occupancy (queued + in flight) == MAX_OUTSTANDING.
  - memAccessWriteBusy uses the same condition.
  - Both are combinational from registered state only.
- Accept:
  - Read accepted when RE && !ReadBusy; write accepted when WE && !WriteBusy.
  - The accepted request enters the FIFO with {we, addr, wdata, serial}.
  - The matching next serial increments by 1 (mod 2^width) on the next edge.
- RE && WE in the same cycle: read wins, write dropped, proto_error set until reset.
- Downstream:
  - mem_req_valid = FIFO non-empty; head fields drive mem_req_*.
  - Pop on valid && ready. On pop, {we, serial} is pushed into the tracker FIFO.
  - Minimum latency: core accept at cycle N → mem_req_valid at N+1.
  - Fields are held stable while valid && !ready.
- Tracker occupancy counts FIFO entries plus in-flight entries; simultaneous accept and response → count unchanged.
- Response: mem_rsp_valid at cycle M pops the tracker head.
  - Read head: memReadDataReady=1, memReadData=rdata, memReadSerial=head serial, all registered, visible at M+1.
  - Write head: memAccessResponseValid=1 with serial at M+1.
  - Pulse outputs are 0 in every other cycle; data and serial outputs hold their last values.
- mem_rsp_valid with empty tracker: ignored, proto_error set.
- Full FIFO with simultaneous pop: busy is still asserted this cycle, with no combinational ready-through.
- Serial wrap: 2^W−1 → 0; the MAX_OUTSTANDING bound prevents aliasing.

Optional Feature:
- CORE_MEM_BRIDGE_PERF_COUNTER_EN defined: adds 32-bit outputs perf_read_count, perf_write_count and perf_busy_cycles.
  - Read/write counts increment on each accepted read/write.
  - perf_busy_cycles counts cycles with RE or WE asserted while the corresponding busy flag is 1.
  - All three are async-cleared by rst, saturate at 2^32−1, and update one cycle after the event.
- Not defined: these ports are absent and no counter logic is generated.

Test Plan:
- Single read to 0x1000, mem_req_ready=1, response 3 cycles after handshake with rdata=0xA5…A5 → mem_req_valid at N+1; memReadDataReady pulse one cycle after mem_rsp_valid; memReadSerial=0; nextMemReadSerial=1.
- Alternating write/read/write with an immediate downstream response → responses in order: write serial 0, read serial 0, write serial 1; the 1-cycle pulses do not overlap.
- Hold mem_req_ready=0 and issue 4 reads → FIFO full, ReadBusy=1, 5th RE not accepted, serial stays 4; release ready → drains, busy deasserts.
- Issue 8 reads with no response → busy at occupancy 8; 16 total reads completed → serial wraps 15→0, with correct serials returned.
- RE=WE=1 at addr 0x20 → one read issued, no write, proto_error=1 until rst low; rst low mid-transfer → all outputs 0 immediately, serials restart at 0.
- With CORE_MEM_BRIDGE_PERF_COUNTER_EN: 3 reads, 2 writes, 5 busy-stalled RE cycles → counters read 3, 2, 5.
